// File: rtl/prbs_err_checker.sv
// ============================================================================
// Module   : prbs_err_checker
// Brief    : PRBS-15 byte-stream bit-error checker with self-seeding and LOS.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs_err_checker #(
    parameter int ERR_W     = 16,
    parameter int LOS_BYTES = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic             valid,
    input  logic [7:0]       data_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      byte_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED0 = 2'd1,
        ST_SEED1 = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [3:0]       c_LOS     = 4'(LOS_BYTES);
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [14:0]      hist_q, hist_d;
    logic [7:0]       seed_q, seed_d;
    logic [3:0]       bad_run_q, bad_run_d;
    logic             locked_q, locked_d;
    logic             err_flag_q, err_flag_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      byte_cnt_q, byte_cnt_d;

    logic [14:0]      w_hist_adv;
    logic [7:0]       w_exp_byte;
    logic [7:0]       w_diff;
    logic [3:0]       w_nerr;
    logic [ERR_W:0]   w_err_sum;
    logic [3:0]       w_run_inc;
    logic [14:0]      w_seed_hist;

    // Iterate b[k] = b[k-14] ^ b[k-15] eight times; first generated bit is the byte MSB.
    always_comb begin
        w_hist_adv = hist_q;
        w_exp_byte = '0;
        for (int i = 0; i < 8; i++) begin
            w_exp_byte[7-i] = w_hist_adv[13] ^ w_hist_adv[14];
            w_hist_adv      = {w_hist_adv[13:0], w_hist_adv[13] ^ w_hist_adv[14]};
        end
    end

    always_comb begin
        w_diff = data_in ^ w_exp_byte;
        w_nerr = '0;
        for (int i = 0; i < 8; i++) begin
            w_nerr = w_nerr + {3'b000, w_diff[i]};
        end
    end

    assign w_err_sum   = {1'b0, err_cnt_q} + {{(ERR_W-3){1'b0}}, w_nerr};
    assign w_run_inc   = bad_run_q + 4'd1;
    assign w_seed_hist = {seed_q[6:0], data_in};

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        seed_d     = seed_q;
        bad_run_d  = bad_run_q;
        locked_d   = locked_q;
        err_flag_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        byte_cnt_d = byte_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SEED0;
            end
            ST_SEED0: begin
                if (valid) begin
                    seed_d  = data_in;
                    state_d = ST_SEED1;
                end
            end
            ST_SEED1: begin
                if (valid) begin
                    hist_d = w_seed_hist;
                    // An all-zero history would lock the reference at zero forever.
                    if (w_seed_hist == 15'd0) begin
                        state_d = ST_SEED0;
                    end else begin
                        state_d  = ST_CHECK;
                        locked_d = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (valid) begin
                    hist_d     = w_hist_adv;
                    err_flag_d = (w_nerr != 4'd0);
                    err_cnt_d  = w_err_sum[ERR_W] ? c_ERR_MAX : w_err_sum[ERR_W-1:0];
                    byte_cnt_d = byte_cnt_q + 32'd1;
                    if (w_nerr == 4'd0) begin
                        bad_run_d = 4'd0;
                    end else if (w_run_inc == c_LOS) begin
                        bad_run_d = 4'd0;
                        state_d   = ST_SEED0;
                        locked_d  = 1'b0;
                    end else begin
                        bad_run_d = w_run_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            err_cnt_d  = '0;
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            hist_q     <= '0;
            seed_q     <= '0;
            bad_run_q  <= '0;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            seed_q     <= seed_d;
            bad_run_q  <= bad_run_d;
            locked_q   <= locked_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign locked   = locked_q;
    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
    assign byte_cnt = byte_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs_err_checker.sv
// ============================================================================
// Module   : tb_prbs_err_checker
// Brief    : Directed bench for prbs_err_checker with a serial-sequence model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prbs_err_checker;

    localparam int LOS = 4;

    logic        CLK;
    logic        RSTn;
    logic        start;
    logic        valid;
    logic [7:0]  data_in;
    logic        clr;
    logic        locked, err_flag;
    logic [15:0] err_cnt;
    logic [31:0] byte_cnt;
    logic        locked4, err_flag4;
    logic [3:0]  err_cnt4;
    logic [31:0] byte_cnt4;

    prbs_err_checker #(.ERR_W(16), .LOS_BYTES(LOS)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .valid(valid), .data_in(data_in),
        .clr(clr), .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt),
        .byte_cnt(byte_cnt)
    );

    prbs_err_checker #(.ERR_W(4), .LOS_BYTES(LOS)) dut4 (
        .CLK(CLK), .RSTn(RSTn), .start(start), .valid(valid), .data_in(data_in),
        .clr(clr), .locked(locked4), .err_flag(err_flag4), .err_cnt(err_cnt4),
        .byte_cnt(byte_cnt4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // Model: the reference is a serial bit list, mq[$] is the newest bit.
    bit          mq[$];
    int          m_mode;   // 0 idle, 1 want first seed, 2 want second seed, 3 checking
    logic [7:0]  m_s0;
    bit          m_locked, m_flag;
    longint      m_total;
    logic [31:0] m_bytes;
    int          m_run;
    bit          cmp_en = 0;

    function automatic logic [7:0] next_ref(input bit advance);
        bit         q[$];
        logic [7:0] r;
        bit         b;
        q = mq;
        r = 8'h00;
        if (q.size() < 15) return 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            b = q[q.size()-14] ^ q[q.size()-15];
            q.push_back(b);
            void'(q.pop_front());
            r[7-i] = b;
        end
        if (advance) mq = q;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_s0 = 8'h00; m_locked = 0; m_flag = 0;
        m_total = 0; m_bytes = 32'd0; m_run = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        logic [15:0] sv;
        logic [7:0]  e;
        int          n;
        m_flag = 0;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: if (v) begin m_s0 = d; m_mode = 2; end
            2: if (v) begin
                sv = {m_s0, d};
                mq.delete();
                for (int i = 14; i >= 0; i--) mq.push_back(sv[i]);
                if (sv[14:0] == 15'd0) m_mode = 1;
                else begin m_mode = 3; m_locked = 1; end
            end
            default: if (v) begin
                e = next_ref(1'b1);
                n = $countones(d ^ e);
                m_flag = (n != 0);
                if (!c) begin m_total += n; m_bytes++; end
                m_run = (n != 0) ? m_run + 1 : 0;
                if (m_run == LOS) begin m_run = 0; m_mode = 1; m_locked = 0; end
            end
        endcase
        if (c) begin m_total = 0; m_bytes = 32'd0; end
    endtask

    always @(negedge CLK) begin
        if (RSTn && cmp_en) begin
            chk("locked",    {63'd0, locked},    {63'd0, m_locked});
            chk("err_flag",  {63'd0, err_flag},  {63'd0, m_flag});
            chk("err_cnt",   {48'd0, err_cnt},   64'(m_total > 65535 ? 65535 : m_total));
            chk("byte_cnt",  {32'd0, byte_cnt},  {32'd0, m_bytes});
            chk("err_cnt4",  {60'd0, err_cnt4},  64'(m_total > 15 ? 15 : m_total));
            chk("locked4",   {63'd0, locked4},   {63'd0, m_locked});
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        valid = v; data_in = d; clr = c;
        @(posedge CLK);
        model_step(v, d, c);
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0] b;
        RSTn = 0; start = 0; valid = 1; clr = 0; data_in = 8'($urandom);
        model_reset();
        repeat (3) begin @(negedge CLK); data_in = 8'($urandom); end
        chk("rst_locked",   {63'd0, locked},   64'd0);
        chk("rst_err_cnt",  {48'd0, err_cnt},  64'd0);
        chk("rst_byte_cnt", {32'd0, byte_cnt}, 64'd0);
        chk("rst_err_flag", {63'd0, err_flag}, 64'd0);
        RSTn = 1; valid = 0;
        cmp_en = 1;

        // Arm, then clean lock on seed 0x0001
        start = 1; step(0, 8'h00, 0); start = 0;
        step(1, 8'h00, 0); step(1, 8'h01, 0);
        chk("lock_after_seed", {63'd0, locked}, 64'd1);
        chk("ref_byte0", {56'd0, next_ref(1'b0)}, 64'h00);
        step(1, 8'h00, 0);
        chk("ref_byte1", {56'd0, next_ref(1'b0)}, 64'h06);
        step(1, 8'h06, 0);
        chk("clean_err_cnt",  {48'd0, err_cnt},  64'd0);
        chk("clean_byte_cnt", {32'd0, byte_cnt}, 64'd2);
        chk("clean_err_flag", {63'd0, err_flag}, 64'd0);

        // Loss of lock: reference continues 0x00, 0x14, 0x00, 0x78
        step(1, 8'hFF, 0); step(1, 8'hFF, 0); step(1, 8'hFF, 0);
        chk("los_still_locked", {63'd0, locked}, 64'd1);
        step(1, 8'hFF, 0);
        chk("los_locked",   {63'd0, locked},   64'd0);
        chk("los_err_cnt",  {48'd0, err_cnt},  64'd26);
        chk("los_byte_cnt", {32'd0, byte_cnt}, 64'd6);
        chk("los_err_cnt4", {60'd0, err_cnt4}, 64'd15);

        step(0, 8'h00, 1);
        chk("clr_err_cnt",  {48'd0, err_cnt},  64'd0);
        chk("clr_byte_cnt", {32'd0, byte_cnt}, 64'd0);

        // Zero seed is rejected, then a proper seed locks
        step(1, 8'h00, 0); step(1, 8'h00, 0);
        chk("zero_seed_unlocked", {63'd0, locked}, 64'd0);
        step(1, 8'h00, 0); step(1, 8'h01, 0);
        chk("reseed_locked", {63'd0, locked}, 64'd1);

        // Single bit error
        step(1, 8'h00, 0); step(1, 8'h07, 0);
        chk("single_flag",     {63'd0, err_flag}, 64'd1);
        chk("single_err_cnt",  {48'd0, err_cnt},  64'd1);
        chk("single_byte_cnt", {32'd0, byte_cnt}, 64'd2);
        step(0, 8'h00, 0);
        chk("single_flag_off", {63'd0, err_flag}, 64'd0);

        // Saturation of the narrow counter
        step(1, next_ref(1'b0), 0);
        repeat (3) step(1, ~next_ref(1'b0), 0);
        chk("sat_err_cnt4", {60'd0, err_cnt4}, 64'd15);
        chk("sat_err_cnt",  {48'd0, err_cnt},  64'd25);
        chk("sat_locked",   {63'd0, locked},   64'd1);

        // Clear wins over a simultaneous erroneous byte
        step(1, next_ref(1'b0), 0);
        step(1, next_ref(1'b0) ^ 8'h01, 1);
        chk("clrhit_flag",     {63'd0, err_flag}, 64'd1);
        chk("clrhit_err_cnt4", {60'd0, err_cnt4}, 64'd0);
        chk("clrhit_byte_cnt", {32'd0, byte_cnt}, 64'd0);
        chk("clrhit_locked",   {63'd0, locked},   64'd1);

        // Asynchronous reset in the middle of checking
        step(1, next_ref(1'b0), 0);
        #3 RSTn = 0;
        #1;
        chk("async_locked",   {63'd0, locked},   64'd0);
        chk("async_err_flag", {63'd0, err_flag}, 64'd0);
        chk("async_byte_cnt", {32'd0, byte_cnt}, 64'd0);
        model_reset();
        @(negedge CLK); RSTn = 1;

        // start low: stays idle
        repeat (3) step(1, 8'($urandom), 0);
        chk("idle_no_lock", {63'd0, locked}, 64'd0);

        start = 1; step(1, 8'h5A, 0); start = 0;
        step(1, 8'hC3, 0); step(1, 8'h21, 0);
        chk("relock", {63'd0, locked}, 64'd1);

        // Mixed traffic with bubbles, sporadic errors and clears
        for (int i = 0; i < 80; i++) begin
            b = next_ref(1'b0);
            if ($urandom_range(0, 7) == 0) b = b ^ 8'($urandom_range(1, 255));
            step(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 19) == 0));
        end

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
